// File: rtl/snes_pad_poller.sv
// rtl/snes_pad_poller.sv - multi-pad SNES/NES controller poller with per-frame edge masks
// Shared latch/clock pair, NUM_PADS serial data lines, autonomous or on-demand frames.
module snes_pad_poller #(
    parameter int NUM_PADS = 2,
    parameter int CLK_DIV  = 16,
    parameter int POLL_DIV = 65536
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     auto_en,
    input  logic                     trigger,
    input  logic                     nes_mode,
    input  logic [NUM_PADS-1:0]      snes_data,
    output logic                     snes_latch,
    output logic                     snes_clock,
    output logic                     busy,
    output logic                     frame_valid,
    output logic [16*NUM_PADS-1:0]   buttons,
    output logic [16*NUM_PADS-1:0]   pressed,
    output logic [16*NUM_PADS-1:0]   released,
    output logic [NUM_PADS-1:0]      present
);

    localparam int TW = $clog2(2 * CLK_DIV) + 1;
    localparam int PW = $clog2(POLL_DIV) + 1;
    localparam logic [TW-1:0] LATCH_END = TW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_END  = TW'(CLK_DIV - 1);
    localparam logic [PW-1:0] POLL_END  = PW'(POLL_DIV - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t                        state, state_nx;
    logic [TW-1:0]                 tmr;
    logic [3:0]                    bit_idx;
    logic [PW-1:0]                 poll_cnt;
    logic                          pending;
    logic                          mode;
    logic [NUM_PADS-1:0][15:0]     raw;
    logic [NUM_PADS-1:0][15:0]     new_btn;
    logic [NUM_PADS-1:0]           new_pres;
    logic                          start;
    logic                          sample;
    logic [3:0]                    sample_idx;
    logic [3:0]                    last_bit;
    logic                          poll_hit;

    assign poll_hit = auto_en && (poll_cnt == POLL_END);
    assign last_bit = mode ? 4'd7 : 4'd15;

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        sample     = 1'b0;
        sample_idx = bit_idx + 4'd1;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_nx = LATCH;
                    start    = 1'b1;
                end
            end
            LATCH: begin
                if (tmr == LATCH_END) begin
                    state_nx   = LOW;
                    sample     = 1'b1;
                    sample_idx = 4'd0;
                end
            end
            LOW: begin
                if (tmr == HALF_END) state_nx = HIGH;
            end
            HIGH: begin
                if (tmr == HALF_END) begin
                    if (bit_idx == last_bit) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = LOW;
                        sample   = 1'b1;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ID nibble is published as read (all ones for a real SNES pad); buttons are inverted.
    always_comb begin
        new_btn  = '0;
        new_pres = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (mode) begin
                new_btn[p]  = {8'h00, ~raw[p][7:0]};
                new_pres[p] = 1'b1;
            end else begin
                new_pres[p] = &raw[p][15:12];
                new_btn[p]  = new_pres[p] ? {raw[p][15:12], ~raw[p][11:0]} : 16'h0000;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            tmr         <= '0;
            bit_idx     <= '0;
            poll_cnt    <= '0;
            pending     <= 1'b0;
            mode        <= 1'b0;
            raw         <= '0;
            snes_latch  <= 1'b0;
            snes_clock  <= 1'b1;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            buttons     <= '0;
            pressed     <= '0;
            released    <= '0;
            present     <= '0;
        end else begin
            tmr      <= (state_nx != state || state == IDLE) ? '0 : tmr + TW'(1);
            poll_cnt <= (!auto_en || poll_hit) ? '0 : poll_cnt + PW'(1);
            // A request landing on the start cycle stays pending for one more frame.
            pending  <= (pending && !start) || trigger || poll_hit;

            if (start) begin
                mode    <= nes_mode;
                bit_idx <= '0;
            end else if (state == HIGH && state_nx == LOW) begin
                bit_idx <= bit_idx + 4'd1;
            end

            if (sample) begin
                for (int p = 0; p < NUM_PADS; p++) raw[p][sample_idx] <= snes_data[p];
            end

            snes_latch  <= (state_nx == LATCH);
            snes_clock  <= (state_nx != LOW);
            busy        <= (state_nx != IDLE);
            frame_valid <= (state_nx == DONE);

            if (state_nx == DONE) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    buttons[16*p +: 16]  <= new_btn[p];
                    pressed[16*p +: 16]  <= new_btn[p] & ~buttons[16*p +: 16];
                    released[16*p +: 16] <= ~new_btn[p] & buttons[16*p +: 16];
                end
                present <= new_pres;
            end
        end
    end

endmodule
